// File: rtl/ctr_block_gen.sv
// ctr_block_gen: CTR-mode counter-block generator. It holds a nonce||counter
// block and streams a bounded run of consecutive blocks to the cipher core
// over a valid/ready handshake. Only the low CTR_W field ever increments;
// overflow of that field either wraps (WRAP_MODE=1) or halts with an error
// (WRAP_MODE=0).
module ctr_block_gen #(
   parameter int BLOCK_W   = 128,
   parameter int CTR_W     = 32,
   parameter int LEN_W     = 16,
   parameter int WRAP_MODE = 0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic [BLOCK_W-1:0] iv_i,
   input  logic               start_i,
   input  logic [LEN_W-1:0]   num_blocks_i,
   output logic [BLOCK_W-1:0] blk_o,
   output logic               blk_valid_o,
   input  logic               blk_ready_i,
   output logic [LEN_W-1:0]   remaining_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               wrap_o,
   output logic               err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Selects the incrementing low field; built by shifting so that
   // CTR_W == BLOCK_W (no nonce bits at all) needs no special case.
   localparam logic [BLOCK_W-1:0] LOW_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

   state_t             state_q;
   logic               run_q;
   logic [BLOCK_W-1:0] counter_q;
   logic [LEN_W-1:0]   remaining_q;
   logic               done_q;
   logic               wrap_q;
   logic               err_q;

   logic [BLOCK_W-1:0] counter_inc;
   logic               low_full;
   logic               last_blk;

   // The carry out of the low field is masked away, so the nonce bits are
   // never disturbed and an all-ones field naturally becomes zero.
   assign counter_inc = (counter_q & ~LOW_MASK) | ((counter_q + BLOCK_W'(1)) & LOW_MASK);
   assign low_full    = (counter_q & LOW_MASK) == LOW_MASK;
   assign last_blk    = remaining_q == LEN_W'(1);

   // Main FSM: reset beats clear, clear beats load, load beats start/handshake.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         run_q       <= 1'b0;
         counter_q   <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (clr_i) begin
         state_q     <= IDLE;
         run_q       <= 1'b0;
         counter_q   <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  counter_q <= iv_i;
                  wrap_q    <= 1'b0;
                  err_q     <= 1'b0;
               end
               if (start_i && (num_blocks_i != '0)) begin
                  state_q     <= RUN;
                  run_q       <= 1'b1;
                  remaining_q <= num_blocks_i;
               end
            end
            RUN: begin
               if (blk_ready_i) begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (low_full && (WRAP_MODE == 0)) begin
                     state_q <= HALT;
                     run_q   <= 1'b0;
                     err_q   <= 1'b1;
                  end else begin
                     counter_q <= counter_inc;
                     if (low_full) begin
                        wrap_q <= 1'b1;
                     end
                     if (last_blk) begin
                        state_q <= IDLE;
                        run_q   <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            HALT: begin
               if (load_i) begin
                  state_q   <= IDLE;
                  counter_q <= iv_i;
                  wrap_q    <= 1'b0;
                  err_q     <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign blk_o       = counter_q;
   assign blk_valid_o = run_q;
   assign busy_o      = run_q;
   assign remaining_o = remaining_q;
   assign done_o      = done_q;
   assign wrap_o      = wrap_q;
   assign err_o       = err_q;

endmodule

// File: doc/ctr_block_gen.md
# ctr_block_gen

Parametrised counter-block generator for the encryptor's CTR-mode keystream path: holds a BLOCK_W-bit counter block (nonce in the upper bits, incrementing field in the low CTR_W bits) and streams a requested number of consecutive blocks to the cipher core over a valid/ready handshake. Unlike the plain free-running counter, it supports IV load, a bounded block budget, and a defined wrap/overflow policy on the incrementing field. It sits between the encryptor control logic and the block-cipher input.

## Interface
- BLOCK_W, 128, total counter-block width.
- CTR_W, 32, width of the incrementing low field; 1 <= CTR_W <= BLOCK_W.
- LEN_W, 16, width of the block-count request.
- WRAP_MODE, 0, 0 = halt with error on field overflow, 1 = wrap to zero and flag.

- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- clr_i  in  1  sync clear: counter, remaining, flags to 0; FSM to IDLE.
- load_i  in  1  sync load of iv_i into counter (IDLE or HALT only).
- iv_i  in  BLOCK_W  initial counter block.
- start_i  in  1  request a run of num_blocks_i blocks (IDLE only).
- num_blocks_i  in  LEN_W  blocks to emit; 0 ignored.
- blk_o  out  BLOCK_W  current counter block.
- blk_valid_o  out  1  blk_o valid.
- blk_ready_i  in  1  consumer accepts blk_o.
- remaining_o  out  LEN_W  blocks left in current run.
- busy_o  out  1  FSM in RUN.
- done_o  out  1  one-cycle pulse after final block accepted.
- wrap_o  out  1  sticky: low field wrapped (WRAP_MODE=1).
- err_o  out  1  sticky: overflow halt (WRAP_MODE=0).

## Operation
- Reset (rst_ni=0 at edge): counter=0, remaining=0, state IDLE; all outputs 0 (blk_o=0).
- Priority per edge: rst_ni > clr_i > load_i > start_i / handshake.
- States: IDLE, RUN, HALT.
- IDLE: load_i writes counter=iv_i. start_i with num_blocks_i!=0 -> RUN, remaining=num_blocks_i. Same-cycle load_i and start_i: load applies, then run starts from iv_i.
- RUN: blk_valid_o=1, blk_o=counter. Handshake = blk_valid_o & blk_ready_i. On handshake: remaining-1; counter[CTR_W-1:0] +1 modulo 2^CTR_W; counter[BLOCK_W-1:CTR_W] never changes (no carry into nonce).
- Final handshake (remaining==1): -> IDLE, done_o=1 next cycle; counter holds next (unused) value.
- Overflow (handshake while low field all-ones): block is delivered normally. WRAP_MODE=1: field -> 0, wrap_o set, run continues. WRAP_MODE=0: counter not incremented, remaining decremented, -> HALT, err_o set; if it was the final block, still -> HALT, no done_o.
- HALT: blk_valid_o=0, busy_o=0; exits only via clr_i (-> IDLE, flags cleared) or load_i (-> IDLE, counter=iv_i, err_o cleared). start_i ignored.
- load_i and start_i ignored in RUN. clr_i in RUN aborts: valid drops next cycle, no done_o.
- wrap_o cleared only by rst_ni, clr_i, or load_i.

## Timing
- start_i at edge t -> blk_valid_o=1, busy_o=1 from t+1.
- Throughput 1 block/cycle with blk_ready_i held high; N blocks occupy cycles t+1..t+N, done_o at t+N+1.
- blk_o, blk_valid_o registered; stable while blk_valid_o & !blk_ready_i.
- blk_valid_o never depends combinationally on blk_ready_i.
- remaining_o, flags update on the edge of the causing event.
- Same-cycle start_i in the done_o cycle is accepted (FSM already IDLE).

## Test plan
- Reset then load iv_i=0x00..00_FFFFFFFE (CTR_W=32), start 4 blocks, ready=1, WRAP_MODE=1 -> blk_o low words FFFFFFFE, FFFFFFFF, 00000000, 00000001; upper 96 bits unchanged; wrap_o=1; done_o one cycle after 4th.
- WRAP_MODE=0, same IV, start 4 -> 2 blocks delivered, err_o=1, state HALT, blk_valid_o=0, remaining_o=2, no done_o; load_i recovers to IDLE with err_o=0.
- Backpressure: start 3, ready pattern 1,0,0,1,1 -> blk_o held during stalls, exactly 3 handshakes, consecutive values, done_o after 5th cycle.
- clr_i asserted mid-run after 2 of 8 blocks -> valid low next cycle, counter=0, remaining_o=0, no done_o.
- start_i with num_blocks_i=0, and load_i during RUN -> both ignored; state, counter unchanged.
- rst_ni low mid-run with clr_i, start_i also high -> all outputs 0, IDLE next cycle.
